load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-stage load/store unit downstream of the pipelined datapath. Consumes the M-stage
//  address (ALUResultM), store data (WriteDataM), funct3M and MemWriteM/MemReadM.
//  Drives a single-outstanding req/ack data bus with byte enables and sign/zero-extends load
//  data back as ReadDataM. Stalls the pipeline (StallM) while a bus access is in flight.
// PARAMETERS
//  TIMEOUT  255  max REQ cycles without bus_ack before the access is aborted with bus_fault
// PORTS
//  clk         in   1   system clock, single clock domain
//  reset       in   1   asynchronous, active-low reset
//  MemReadM    in   1   M-stage load (ResultSrcM==2'b01)
//  MemWriteM   in   1   M-stage store
//  funct3M     in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  AddrM       in   32  byte address
//  WriteDataM  in   32  store data, LSB-aligned
//  ReadDataM   out  32  extended load data, valid in DONE
//  StallM      out  1   freeze F/D/E/M pipeline registers
//  misalign    out  1   1-cycle pulse: misaligned access suppressed
//  bus_fault   out  1   1-cycle pulse: bus_err or timeout
//  bus_req     out  1   request valid
//  bus_we      out  1   1=write
//  bus_addr    out  32  word address {AddrM[31:2],2'b00}
//  bus_be      out  4   byte enables
//  bus_wdata   out  32  lane-aligned store data
//  bus_ack     in   1   access complete
//  bus_rdata   in   32  read word, valid with bus_ack
//  bus_err     in   1   access failed, valid with bus_ack
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE, all outputs 0, timeout counter 0; bus_req drops at once.
//  States: IDLE -> REQ -> DONE -> IDLE.
//  IDLE: access = MemReadM|MemWriteM. If access is aligned: StallM=1, register bus_addr/we/be/
//   wdata, -> REQ. If access is misaligned (H with AddrM[0]!=0, W with AddrM[1:0]!=0): no bus
//   cycle, misalign=1, StallM=0, ReadDataM=0, store dropped, stay IDLE. If no access: idle.
//  REQ: bus_req=1, StallM=1; bus outputs held stable. Counter increments each cycle.
//   bus_ack&~bus_err: capture bus_rdata -> DONE. bus_ack&bus_err, or counter==TIMEOUT-1:
//   bus_fault=1, captured data=0 -> DONE.
//  DONE: StallM=0, ReadDataM valid. Pipeline advances at the cycle edge. -> IDLE.
//   DONE blocks re-issue of the same access.
//  Minimum latency is 2 stall cycles (IDLE + REQ with ack in same cycle). Data is in DONE.
//  bus_ack/bus_err are ignored outside REQ. Both MemRead&MemWrite set: treated as store.
//  Store lanes (o=AddrM[1:0]):
//   SB: be=4'b0001<<o, wdata={4{WD[7:0]}}
//   SH: be=4'b0011<<o, wdata={2{WD[15:0]}}
//   SW: be=4'hF, wdata=WD
//   Loads drive be=4'hF.
//  Load: sh=bus_rdata>>(8*o). LB/LH sign-extend sh[7:0]/sh[15:0]; LBU/LHU zero-extend;
//   LW passes sh through. Undefined funct3: treated as W.
//  Counter width = clog2(TIMEOUT+1). Counter is cleared on entry to REQ and saturates (no wrap).
// STRUCTURE
//  Shared header mem_defs.vh: funct3 size codes (F3_B/H/W/BU/HU) and FSM state encodings
//   (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
//  Sub-module load_extend (combinational): rdata, offset, funct3 -> ReadData.
//  FSM, counter and store-lane logic live inline.
// TESTING
//  1 SW AddrM=0x100 WD=0xDEADBEEF, ack after 3 cycles -> be=F, wdata=DEADBEEF, StallM high 4 cycles.
//  2 LB AddrM=0x103, rdata=0x80FF_0000, ack same cycle -> ReadDataM=0xFFFFFF80; LBU -> 0x00000080.
//  3 SH AddrM=0x102 WD=0x1234 -> be=4'b1100, wdata=0x12341234; LH at 0x101 -> misalign pulse, no bus_req, no stall.
//  4 LW with no ack, TIMEOUT=8 -> bus_fault after 8 REQ cycles, ReadDataM=0, return to IDLE.
//  5 reset asserted while in REQ -> bus_req=0 immediately; after release, next load proceeds normally.
//  6 back-to-back LW,SW -> exactly one bus_req per access, no duplicate after DONE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, FSM states and access-size helpers
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Unsigned variants only exist for loads; any other code falls back to a word access.
    function automatic size_t access_size(input logic [2:0] f3, input logic store);
        size_t sz;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_W:    sz = SZ_W;
            F3_BU:   sz = store ? SZ_W : SZ_B;
            F3_HU:   sz = store ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_aligned(input size_t sz, input logic [1:0] offset);
        logic ok;
        case (sz)
            SZ_H:    ok = ~offset[0];
            SZ_W:    ok = (offset == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - lane select and sign/zero extension of load data
module load_store_unit_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend according to size/sign.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    read_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    read_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   read_data = {24'd0, shifted[7:0]};
            F3_HU:   read_data = {16'd0, shifted[15:0]};
            default: read_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with single-outstanding req/ack bus
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        misalign,
    output logic        bus_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    lsu_state_t  state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0] rdata_q;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    logic [31:0] ext_data;

    logic        access;
    logic        aligned;
    logic        issue;
    logic        ack_ok;
    logic [1:0]  offset;
    size_t       size;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;

    assign access  = MemReadM | MemWriteM;
    assign offset  = AddrM[1:0];
    assign size    = access_size(funct3M, MemWriteM);
    assign aligned = is_aligned(size, offset);

    // Next-state and handshake outputs; IDLE outputs are gated so reset forces them low.
    always_comb begin
        state_n   = state;
        StallM    = 1'b0;
        misalign  = 1'b0;
        bus_fault = 1'b0;
        bus_req   = 1'b0;
        issue     = 1'b0;
        ack_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (reset && access) begin
                    if (aligned) begin
                        StallM  = 1'b1;
                        issue   = 1'b1;
                        state_n = REQ;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            REQ: begin
                bus_req = 1'b1;
                StallM  = 1'b1;
                if (bus_ack && !bus_err) begin
                    ack_ok  = 1'b1;
                    state_n = DONE;
                end else if ((bus_ack && bus_err) || (cnt == CNT_LAST)) begin
                    bus_fault = 1'b1;
                    state_n   = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Store lane placement: replicate the datum across the word, enable only its bytes.
    always_comb begin
        be_n    = 4'hF;
        wdata_n = 32'd0;
        if (MemWriteM) begin
            case (size)
                SZ_B: begin
                    be_n    = 4'b0001 << offset;
                    wdata_n = {4{WriteDataM[7:0]}};
                end
                SZ_H: begin
                    be_n    = 4'b0011 << offset;
                    wdata_n = {2{WriteDataM[15:0]}};
                end
                default: wdata_n = WriteDataM;
            endcase
        end
    end

    // State, timeout counter, bus request registers and captured read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            offset_q  <= 2'd0;
            funct3_q  <= 3'd0;
        end else begin
            state <= state_n;
            if (issue) begin
                cnt       <= '0;
                bus_we    <= MemWriteM;
                bus_addr  <= {AddrM[31:2], 2'b00};
                bus_be    <= be_n;
                bus_wdata <= wdata_n;
                rdata_q   <= 32'd0;
                offset_q  <= offset;
                funct3_q  <= funct3M;
            end else if (state == REQ) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
                if (ack_ok && !bus_we) begin
                    rdata_q <= bus_rdata;
                end
            end
        end
    end

    load_store_unit_load_extend u_extend (
        .rdata     (rdata_q),
        .offset    (offset_q),
        .funct3    (funct3_q),
        .read_data (ext_data)
    );

    assign ReadDataM = (state == DONE) ? ext_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized bench with behavioural LSU model
module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        misalign;
    logic        bus_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks;
    int errors;
    int req_starts;
    logic prev_req;
    bit in_done;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .misalign   (misalign),
        .bus_fault  (bus_fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count distinct bus requests (rising edges of bus_req).
    always @(negedge clk) begin
        if (bus_req && !prev_req) req_starts <= req_starts + 1;
        prev_req <= bus_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_size(input bit st, input bit [2:0] f3);
        if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input bit st, input int sz, input logic [31:0] addr);
        int o;
        o = int'(addr % 4);
        if (!st) return 4'hF;
        return 4'(((1 << sz) - 1) << o);
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input bit [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int sz;
        longint v;
        longint span;
        sz   = model_size(1'b0, f3);
        span = longint'(1) << (8 * sz);
        v    = longint'(rd) >> (8 * int'(addr % 4));
        v    = v % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic drop_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'd0;
        AddrM      = 32'd0;
        WriteDataM = 32'd0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_done = 1'b0;
            #1;
            chk("idle_req", {31'd0, bus_req}, 32'd0);
        end
    endtask

    // One access from the M stage, presented in IDLE or (back-to-back) during the prior DONE.
    // ack_at: REQ cycle (1-based) in which the bus acknowledges, 0 = never.
    task automatic run_access(input string tag, input bit st, input bit [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_at, input bit err, input logic [31:0] rd);
        int sz, reqs, stalls, exp_reqs;
        bit done_seen, failed;
        sz = model_size(st, f3);
        MemReadM   = !st;
        MemWriteM  = st;
        funct3M    = f3;
        AddrM      = addr;
        WriteDataM = wd;
        if (in_done) @(negedge clk);
        in_done = 1'b0;
        #1;
        if ((addr % sz) != 0) begin
            chk({tag, "_misalign"}, {31'd0, misalign}, 32'd1);
            chk({tag, "_mis_stall"}, {31'd0, StallM}, 32'd0);
            chk({tag, "_mis_rdata"}, ReadDataM, 32'd0);
            @(negedge clk);
            drop_inputs();
            #1;
            chk({tag, "_mis_noreq"}, {31'd0, bus_req}, 32'd0);
            return;
        end
        chk({tag, "_nomis"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_stall0"}, {31'd0, StallM}, 32'd1);
        exp_reqs  = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
        failed    = err || (ack_at < 1) || (ack_at > TO);
        reqs      = 0;
        stalls    = 1;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge clk);
            if (bus_req) begin
                reqs++;
                if (StallM) stalls++;
                chk({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
                chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, st});
                chk({tag, "_be"}, {28'd0, bus_be}, {28'd0, model_be(st, sz, addr)});
                if (st) chk({tag, "_wdata"}, bus_wdata, model_wdata(sz, wd));
                bus_ack   = (reqs == ack_at);
                bus_err   = err && (reqs == ack_at);
                bus_rdata = (reqs == ack_at) ? rd : $urandom;
                #1;
                chk({tag, "_fault"}, {31'd0, bus_fault},
                    {31'd0, (reqs == exp_reqs) && failed});
            end else begin
                bus_ack   = 1'b0;
                bus_err   = 1'b0;
                done_seen = 1'b1;
                #1;
                chk({tag, "_done_stall"}, {31'd0, StallM}, 32'd0);
                chk({tag, "_reqs"}, reqs, exp_reqs);
                chk({tag, "_stalls"}, stalls, 1 + exp_reqs);
                if (!st) chk({tag, "_rdata"}, ReadDataM, failed ? 32'd0 : model_load(f3, addr, rd));
                drop_inputs();
                in_done = 1'b1;
            end
        end
        chk({tag, "_completed"}, {31'd0, done_seen}, 32'd1);
    endtask

    initial begin
        int base;
        bit st, err;
        bit [2:0] f3;
        logic [31:0] addr;
        int sz;
        checks     = 0;
        errors     = 0;
        req_starts = 0;
        prev_req   = 1'b0;
        in_done    = 1'b0;
        reset      = 1'b0;
        bus_ack    = 1'b0;
        bus_err    = 1'b0;
        bus_rdata  = 32'd0;
        drop_inputs();
        #1;
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_access("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 1'b0, 32'd0);
        run_access("lb", 1'b0, 3'b000, 32'h103, 32'd0, 1, 1'b0, 32'h80FF0000);
        run_access("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 1, 1'b0, 32'h80FF0000);
        run_access("sh", 1'b1, 3'b001, 32'h102, 32'h00001234, 2, 1'b0, 32'd0);
        run_access("lh_mis", 1'b0, 3'b001, 32'h101, 32'd0, 1, 1'b0, 32'd0);
        run_access("timeout", 1'b0, 3'b010, 32'h300, 32'd0, 0, 1'b0, 32'h12345678);
        run_access("buserr", 1'b0, 3'b010, 32'h304, 32'd0, 2, 1'b1, 32'h12345678);

        idle_cycles(1);
        bus_ack = 1'b1;
        bus_err = 1'b1;
        #1;
        chk("stray_ack_fault", {31'd0, bus_fault}, 32'd0);
        chk("stray_ack_stall", {31'd0, StallM}, 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        bus_err = 1'b0;
        #1;
        chk("stray_ack_noreq", {31'd0, bus_req}, 32'd0);

        MemReadM = 1'b1;
        funct3M  = 3'b010;
        AddrM    = 32'h200;
        @(negedge clk);
        chk("rst_mid_req", {31'd0, bus_req}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_drop", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, StallM}, 32'd0);
        chk("rst_mid_addr", bus_addr, 32'd0);
        drop_inputs();
        @(negedge clk);
        reset   = 1'b1;
        in_done = 1'b0;
        run_access("post_rst_lw", 1'b0, 3'b010, 32'h204, 32'd0, 2, 1'b0, 32'hCAFEF00D);

        idle_cycles(1);
        base = req_starts;
        run_access("b2b_lw", 1'b0, 3'b010, 32'h400, 32'd0, 1, 1'b0, 32'hA5A55A5A);
        run_access("b2b_sw", 1'b1, 3'b010, 32'h404, 32'h0BADF00D, 1, 1'b0, 32'd0);
        idle_cycles(3);
        chk("b2b_req_count", req_starts - base, 32'd2);

        for (int i = 0; i < 20; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sz = model_size(st, f3);
            addr = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(0, 3));
            else addr = addr + 32'(sz * $urandom_range(0, (4 / sz) - 1));
            err = ($urandom_range(0, 7) == 0);
            run_access("rand", st, f3, addr, $urandom, $urandom_range(1, 4), err, $urandom);
        end
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
